// File: rtl/segment_mux_driver.sv
// -----------------------------------------------------------------------------
// segment_mux_driver
//   Drives a 4-digit multiplexed 7-segment display from the 2-bit digit select
//   produced by display_controller. A 4-digit hex value is accepted over a
//   valid/ready handshake into a pending register and copied into the shadow
//   (displayed) register only at a frame boundary (SEL 3 -> 0), so a frame
//   never mixes old and new digits. Every SEL change turns all anodes off for
//   BLANK_CYCLES cycles to prevent ghosting. Optional leading-zero blanking.
//
// Ports
//   CLK         in   1   system clock
//   RST         in   1   synchronous, active-high reset
//   SEL         in   2   digit select, 0 = least-significant digit
//   DIGITS_IN   in   16  new value, digit k = DIGITS_IN[4k+3:4k]
//   DP_IN       in   4   decimal point per digit, 1 = lit
//   LOAD_VALID  in   1   DIGITS_IN/DP_IN valid
//   LOAD_READY  out  1   block can accept a load
//   LZ_BLANK    in   1   1 = leading-zero suppression on (live)
//   AN          out  4   anodes, active-low
//   SEG         out  7   segments {g,f,e,d,c,b,a}, active-low
//   DP          out  1   decimal point, active-low
// -----------------------------------------------------------------------------
module segment_mux_driver #(
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  SEL,
    input  logic [15:0] DIGITS_IN,
    input  logic [3:0]  DP_IN,
    input  logic        LOAD_VALID,
    output logic        LOAD_READY,
    input  logic        LZ_BLANK,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Digit k is a leading zero when it and all more-significant digits are 0;
    // digit 0 always shows.
    function automatic logic is_leading_zero(input logic [15:0] value,
                                             input logic [1:0]  k);
        logic [15:0] upper;
        upper = value >> {k, 2'b00};
        return (k != 2'd0) && (upper == 16'h0000);
    endfunction

    logic [1:0]       sel_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [15:0]      pend_digits_r;
    logic [3:0]       pend_dp_r;
    logic [15:0]      shadow_digits_r;
    logic [3:0]       shadow_dp_r;

    logic             chg_s;
    logic             boundary_s;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_s;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    logic             dp_s;
    logic [3:0]       digit_s;
    logic [3:0]       drive_an_s;
    logic [6:0]       drive_seg_s;
    logic             drive_dp_s;

    assign chg_s      = (SEL != sel_r);
    assign boundary_s = (sel_r == 2'd3) && (SEL == 2'd0);

    // Output pattern for the currently selected digit while driving.
    always_comb begin
        drive_an_s = ~(4'b0001 << sel_r);
        digit_s    = shadow_digits_r[{sel_r, 2'b00} +: 4];
        if (LZ_BLANK && is_leading_zero(shadow_digits_r, sel_r)) begin
            drive_seg_s = 7'h7F;
        end else begin
            drive_seg_s = seg_decode(digit_s);
        end
        drive_dp_s = ~shadow_dp_r[sel_r];
    end

    // Blank/drive next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        an_s    = 4'hF;
        seg_s   = 7'h7F;
        dp_s    = 1'b1;
        case (state_r)
            ST_BLANK: begin
                if (chg_s) begin
                    cnt_s = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_MAX) begin
                    state_s = ST_DRIVE;
                    cnt_s   = {CNT_W{1'b0}};
                    an_s    = drive_an_s;
                    seg_s   = drive_seg_s;
                    dp_s    = drive_dp_s;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (chg_s) begin
                    state_s = ST_BLANK;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    an_s  = drive_an_s;
                    seg_s = drive_seg_s;
                    dp_s  = drive_dp_s;
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // SEL tracking, FSM state and registered display outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_r   <= 2'd0;
            state_r <= ST_BLANK;
            cnt_r   <= {CNT_W{1'b0}};
            AN      <= 4'hF;
            SEG     <= 7'h7F;
            DP      <= 1'b1;
        end else begin
            sel_r   <= SEL;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            AN      <= an_s;
            SEG     <= seg_s;
            DP      <= dp_s;
        end
    end

    // Load handshake: LOAD_READY low means a load is pending; the pending value
    // moves to the shadow at the next frame boundary. A load accepted on a
    // boundary edge is not yet pending there, so it waits for the next one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_digits_r   <= 16'h0000;
            pend_dp_r       <= 4'h0;
            shadow_digits_r <= 16'h0000;
            shadow_dp_r     <= 4'h0;
            LOAD_READY      <= 1'b1;
        end else if (LOAD_VALID && LOAD_READY) begin
            pend_digits_r <= DIGITS_IN;
            pend_dp_r     <= DP_IN;
            LOAD_READY    <= 1'b0;
        end else if (boundary_s && !LOAD_READY) begin
            shadow_digits_r <= pend_digits_r;
            shadow_dp_r     <= pend_dp_r;
            LOAD_READY      <= 1'b1;
        end else begin
            LOAD_READY <= LOAD_READY;
        end
    end

endmodule

// File: tb/tb_segment_mux_driver.sv
module tb_segment_mux_driver;

    localparam int BC = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  SEL;
    logic [15:0] DIGITS_IN;
    logic [3:0]  DP_IN;
    logic        LOAD_VALID;
    logic        LOAD_READY;
    logic        LZ_BLANK;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int checks = 0;
    int errors = 0;

    segment_mux_driver #(.BLANK_CYCLES(BC)) dut (
        .CLK(CLK), .RST(RST), .SEL(SEL), .DIGITS_IN(DIGITS_IN), .DP_IN(DP_IN),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY), .LZ_BLANK(LZ_BLANK),
        .AN(AN), .SEG(SEG), .DP(DP)
    );

    always #5 CLK = ~CLK;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: anodes dark until BC edges have passed since the last edge that saw
    // SEL differ from its previous sampled value (reset counts as such an edge).
    int          ed = 0;
    int          m_last_chg = 0;
    int          m_selq = 0;
    int          m_shadow = 0, m_sdp = 0, m_pend = 0, m_pdp = 0;
    bit          m_ready = 1'b1;
    int          e_an, e_seg, e_dp, dig;
    bit          acc, com;

    initial begin
        forever begin
            @(posedge CLK);
            ed++;
            if (RST) begin
                m_selq = 0; m_last_chg = ed; m_shadow = 0; m_sdp = 0;
                m_pend = 0; m_pdp = 0; m_ready = 1'b1;
            end else begin
                acc = LOAD_VALID && m_ready;
                com = (m_selq == 3) && (int'(SEL) == 0) && !m_ready;
                if (acc) begin
                    m_pend = int'(DIGITS_IN); m_pdp = int'(DP_IN); m_ready = 1'b0;
                end else if (com) begin
                    m_shadow = m_pend; m_sdp = m_pdp; m_ready = 1'b1;
                end
                if (int'(SEL) != m_selq) m_last_chg = ed;
                m_selq = int'(SEL);
            end
            if (ed - m_last_chg >= BC) begin
                e_an = 15 & ~(1 << m_selq);
                dig  = (m_shadow >> (4 * m_selq)) & 15;
                if (LZ_BLANK && m_selq > 0 && (m_shadow >> (4 * m_selq)) == 0)
                    e_seg = 'h7F;
                else
                    e_seg = int'(segtab[dig]);
                e_dp = ((m_sdp >> m_selq) & 1) ? 0 : 1;
            end else begin
                e_an = 'hF; e_seg = 'h7F; e_dp = 1;
            end
            #1;
            chk("model_AN", int'(AN), e_an);
            chk("model_SEG", int'(SEG), e_seg);
            chk("model_DP", int'(DP), e_dp);
            chk("model_READY", int'(LOAD_READY), int'(m_ready));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; SEL = 2'd0; DIGITS_IN = 16'h0; DP_IN = 4'h0;
        LOAD_VALID = 1'b0; LZ_BLANK = 1'b0;
        // 1. reset and release
        cyc(3);
        chk("rst_AN", int'(AN), 'hF);
        chk("rst_SEG", int'(SEG), 'h7F);
        chk("rst_DP", int'(DP), 1);
        chk("rst_READY", int'(LOAD_READY), 1);
        RST = 1'b0;
        cyc(3); chk("rel_blank_AN", int'(AN), 'hF);
        cyc(1); chk("rel_AN", int'(AN), 'hE); chk("rel_SEG", int'(SEG), 'h40);
        // 2. load 1234 at SEL=1, commit at boundary
        SEL = 2'd1; LOAD_VALID = 1'b1; DIGITS_IN = 16'h1234; DP_IN = 4'b0001;
        cyc(1); LOAD_VALID = 1'b0;
        chk("load_READY0", int'(LOAD_READY), 0);
        cyc(4); chk("old_s1_SEG", int'(SEG), 'h40); chk("old_s1_AN", int'(AN), 'hD);
        SEL = 2'd2; cyc(5); chk("old_s2_SEG", int'(SEG), 'h40);
        SEL = 2'd3; cyc(5); chk("old_s3_SEG", int'(SEG), 'h40);
        SEL = 2'd0; cyc(1); chk("commit_READY1", int'(LOAD_READY), 1);
        cyc(4); chk("new_s0_SEG", int'(SEG), 'h19); chk("new_s0_DP", int'(DP), 0);
        SEL = 2'd2; cyc(5); chk("new_s2_SEG", int'(SEG), 'h24); chk("new_s2_AN", int'(AN), 'hB);
        // 3. blanking and restart
        SEL = 2'd1; cyc(1); chk("chg_AN", int'(AN), 'hF);
        cyc(3); chk("chg_hold_AN", int'(AN), 'hF);
        cyc(1); chk("chg_drive_AN", int'(AN), 'hD); chk("chg_drive_SEG", int'(SEG), 'h30);
        SEL = 2'd2; cyc(2);
        SEL = 2'd3; cyc(4); chk("restart_AN", int'(AN), 'hF);
        cyc(1); chk("restart_drive_AN", int'(AN), 'h7); chk("restart_SEG", int'(SEG), 'h79);
        // 4. leading-zero suppression
        LOAD_VALID = 1'b1; DIGITS_IN = 16'h0040; DP_IN = 4'h0;
        cyc(1); LOAD_VALID = 1'b0; LZ_BLANK = 1'b1;
        SEL = 2'd0; cyc(5); chk("lz_d0", int'(SEG), 'h40);
        SEL = 2'd1; cyc(5); chk("lz_d1", int'(SEG), 'h19);
        SEL = 2'd2; cyc(5); chk("lz_d2", int'(SEG), 'h7F); chk("lz_d2_AN", int'(AN), 'hB);
        SEL = 2'd3; cyc(5); chk("lz_d3", int'(SEG), 'h7F);
        LZ_BLANK = 1'b0; cyc(1); chk("lz_off_d3", int'(SEG), 'h40);
        LZ_BLANK = 1'b1;
        LOAD_VALID = 1'b1; DIGITS_IN = 16'h0000;
        cyc(1); LOAD_VALID = 1'b0;
        SEL = 2'd0; cyc(5); chk("lz0_d0", int'(SEG), 'h40);
        SEL = 2'd1; cyc(5); chk("lz0_d1", int'(SEG), 'h7F);
        LZ_BLANK = 1'b0; cyc(1); chk("lz0_off_d1", int'(SEG), 'h40);
        // 5. backpressure
        LOAD_VALID = 1'b1; DIGITS_IN = 16'h5678; DP_IN = 4'h0;
        cyc(1); DIGITS_IN = 16'hABCD;
        chk("bp_READY0", int'(LOAD_READY), 0);
        SEL = 2'd2; cyc(5);
        SEL = 2'd3; cyc(5);
        SEL = 2'd0; cyc(1); chk("bp_commit_READY", int'(LOAD_READY), 1);
        cyc(1); LOAD_VALID = 1'b0; chk("bp_accept_READY", int'(LOAD_READY), 0);
        cyc(3); chk("bp_5678_d0", int'(SEG), 'h00);
        SEL = 2'd1; cyc(5);
        SEL = 2'd2; cyc(5);
        SEL = 2'd3; cyc(5);
        SEL = 2'd0; cyc(5); chk("bp_abcd_d0", int'(SEG), 'h21);
        SEL = 2'd3; cyc(5); chk("bp_abcd_d3", int'(SEG), 'h08);
        // 6. reset with a load pending
        LOAD_VALID = 1'b1; DIGITS_IN = 16'h9999; DP_IN = 4'hF;
        SEL = 2'd1; cyc(1); LOAD_VALID = 1'b0; cyc(1);
        RST = 1'b1; SEL = 2'd0; cyc(2);
        chk("rst2_AN", int'(AN), 'hF); chk("rst2_SEG", int'(SEG), 'h7F);
        chk("rst2_DP", int'(DP), 1); chk("rst2_READY", int'(LOAD_READY), 1);
        RST = 1'b0; cyc(4);
        chk("rst2_d0", int'(SEG), 'h40); chk("rst2_d0_DP", int'(DP), 1);
        SEL = 2'd1; cyc(5);
        SEL = 2'd2; cyc(5);
        SEL = 2'd3; cyc(5);
        SEL = 2'd0; cyc(5); chk("rst2_nocommit_d0", int'(SEG), 'h40);
        chk("rst2_nocommit_DP", int'(DP), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
